// File: rtl/median_frame_arbiter_if.sv
// median_frame_arbiter_if: one 8-bit AXI4-Stream pixel link.
// tUser marks start of frame, tLast marks end of line.
interface median_frame_arbiter_if;
  logic [7:0] tData;
  logic       tValid;
  logic       tReady;
  logic       tUser;
  logic       tLast;

  modport master (output tData, output tValid, output tUser, output tLast, input tReady);
  modport slave  (input tData, input tValid, input tUser, input tLast, output tReady);
endinterface

// File: rtl/median_frame_arbiter.sv
// median_frame_arbiter: shares one median filter between two 8-bit pixel
// streams, granting whole frames round-robin and regenerating SOF/EOL
// markers from its own column/row counters.
// Optional feature: define MEDIAN_ARB_FLUSH_EN to append FLUSH_LEN beats of
// FLUSH_VALUE after every frame so the filter line buffer drains.
module median_frame_arbiter #(
  parameter int         WIDTH       = 240,
  parameter int         HEIGHT      = 200,
  parameter logic [7:0] FLUSH_VALUE = 8'h00,
  parameter int         FLUSH_LEN   = 2*WIDTH+3
) (
  input  logic                  clk,
  input  logic                  reset,
  median_frame_arbiter_if.slave  AXIS_In0,
  median_frame_arbiter_if.slave  AXIS_In1,
  median_frame_arbiter_if.master AXIS_Out,
  output logic                  grant_id,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  fmt_err
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
`ifdef MEDIAN_ARB_FLUSH_EN
  localparam int FL_W = $clog2(FLUSH_LEN + 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_LEN - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    GRANT
`ifdef MEDIAN_ARB_FLUSH_EN
    , FLUSH
`endif
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             last_grant;
`ifdef MEDIAN_ARB_FLUSH_EN
  logic [FL_W-1:0]  flush_cnt;
`endif

  logic [7:0] sel_data;
  logic       sel_valid;
  logic       sel_user;
  logic       sel_last;
  logic       col_is_last;
  logic       at_origin;
  logic       out_hs;
  logic       elig0;
  logic       elig1;
  logic       next_gid;
  logic       in0_ready;
  logic       in1_ready;

  // Select the granted source and derive the counter-based markers and arbitration pick.
  always_comb begin
    sel_data    = grant_id ? AXIS_In1.tData  : AXIS_In0.tData;
    sel_valid   = grant_id ? AXIS_In1.tValid : AXIS_In0.tValid;
    sel_user    = grant_id ? AXIS_In1.tUser  : AXIS_In0.tUser;
    sel_last    = grant_id ? AXIS_In1.tLast  : AXIS_In0.tLast;
    col_is_last = (col == COL_LAST);
    at_origin   = (col == '0) && (row == '0);
    out_hs      = sel_valid && AXIS_Out.tReady;
    elig0       = AXIS_In0.tValid && AXIS_In0.tUser;
    elig1       = AXIS_In1.tValid && AXIS_In1.tUser;
    next_gid    = (elig0 && elig1) ? ~last_grant : elig1;
  end

  // Output mux: zero-latency pass-through while granted, flush filler while draining, ungranted sources drop non-SOF beats and hold SOF.
  always_comb begin
    AXIS_Out.tData  = FLUSH_VALUE;
    AXIS_Out.tValid = 1'b0;
    AXIS_Out.tUser  = 1'b0;
    AXIS_Out.tLast  = 1'b0;
    in0_ready       = AXIS_In0.tValid && !AXIS_In0.tUser;
    in1_ready       = AXIS_In1.tValid && !AXIS_In1.tUser;
    case (state)
      GRANT: begin
        AXIS_Out.tData  = sel_data;
        AXIS_Out.tValid = sel_valid;
        AXIS_Out.tUser  = at_origin;
        AXIS_Out.tLast  = col_is_last;
        if (grant_id) begin
          in1_ready = AXIS_Out.tReady;
        end else begin
          in0_ready = AXIS_Out.tReady;
        end
      end
`ifdef MEDIAN_ARB_FLUSH_EN
      FLUSH: begin
        AXIS_Out.tData  = FLUSH_VALUE;
        AXIS_Out.tValid = 1'b1;
        AXIS_Out.tLast  = col_is_last;
      end
`endif
      default: ;
    endcase
  end

  assign AXIS_In0.tReady = in0_ready;
  assign AXIS_In1.tReady = in1_ready;

  // Frame-level FSM: arbitrate in IDLE, count the granted frame, optionally drain, and flag marker mismatches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      fmt_err    <= 1'b0;
`ifdef MEDIAN_ARB_FLUSH_EN
      flush_cnt  <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            grant_id <= next_gid;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (out_hs) begin
            if ((sel_last != col_is_last) || (sel_user && !at_origin)) begin
              fmt_err <= 1'b1;
            end
            if (col_is_last) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row        <= '0;
                last_grant <= grant_id;
`ifdef MEDIAN_ARB_FLUSH_EN
                state      <= FLUSH;
                flush_cnt  <= '0;
`else
                state      <= IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
`endif
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
`ifdef MEDIAN_ARB_FLUSH_EN
        FLUSH: begin
          if (AXIS_Out.tReady) begin
            col <= col_is_last ? '0 : col + 1'b1;
            if (flush_cnt == FL_LAST) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              col        <= '0;
              flush_cnt  <= '0;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_frame_arbiter.sv
// tb_median_frame_arbiter: randomized bench for median_frame_arbiter with a
// frame-level reference model (queues of expected beats, grant order).
// Honors MEDIAN_ARB_FLUSH_EN the same way the design does.
module tb_median_frame_arbiter;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int FL    = 11;
  localparam int FRAME = W * H;
`ifdef MEDIAN_ARB_FLUSH_EN
  localparam int EXP_FLUSH = FL;
`else
  localparam int EXP_FLUSH = 0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       user;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic grant_id, busy, frame_done, fmt_err;

  logic [1:0] dv = '0;
  logic [1:0] du = '0;
  logic [1:0] dl = '0;
  logic [7:0] dd [2];
  logic       rdy = 1'b0;

  median_frame_arbiter_if in0_if ();
  median_frame_arbiter_if in1_if ();
  median_frame_arbiter_if out_if ();

  assign in0_if.tData  = dd[0];
  assign in0_if.tValid = dv[0];
  assign in0_if.tUser  = du[0];
  assign in0_if.tLast  = dl[0];
  assign in1_if.tData  = dd[1];
  assign in1_if.tValid = dv[1];
  assign in1_if.tUser  = du[1];
  assign in1_if.tLast  = dl[1];
  assign out_if.tReady = rdy;

  median_frame_arbiter #(
    .WIDTH(W), .HEIGHT(H), .FLUSH_VALUE(8'h00), .FLUSH_LEN(FL)
  ) dut (
    .clk(clk), .reset(reset),
    .AXIS_In0(in0_if), .AXIS_In1(in1_if), .AXIS_Out(out_if),
    .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  beat_t q0[$];
  beat_t q1[$];
  beat_t exp_q[$];
  int    seen_grants[$];

  int m_phase = 0;
  int m_src = 0;
  int m_beat = 0;
  int m_flush = 0;
  bit m_last = 1'b1;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_err = 1'b0;
  bit m_fresh = 1'b1;
  bit m_new = 1'b0;

  logic [1:0] s_hs_in = '0;
  bit s_hs_out = 1'b0;
  bit rst_req = 1'b1;
  int p_valid = 100;
  int p_ready = 100;
  int stall_beat = -1;
  int stall_flush = -1;
  int stall_left = 0;

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qat(input int i, input int k);
    return (i == 0) ? q0[k] : q1[k];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic enqueueFrame(input int src, input logic [7:0] base, input int err_beat, input int err_kind);
    beat_t b;
    for (int k = 0; k < FRAME; k++) begin
      b.data = base + 8'(k);
      b.user = (k == 0);
      b.last = ((k % W) == W - 1);
      if (k == err_beat) begin
        if (err_kind == 1) b.last = ~b.last;
        else b.user = 1'b1;
      end
      if (src == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  task automatic enqueueGarbage(input int src, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = 8'($urandom);
      b.user = 1'b0;
      b.last = 1'($urandom);
      if (src == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  task automatic checkCycle();
    bit ev;
    beat_t eb;
    s_hs_in[0] = dv[0] && in0_if.tReady;
    s_hs_in[1] = dv[1] && in1_if.tReady;
    ev = (m_phase == 1) ? dv[m_src] : (m_phase == 2);
    s_hs_out = ev && rdy;
    if (reset) return;
    checkOutput("out_valid", 32'(out_if.tValid), 32'(ev));
    checkOutput("busy", 32'(busy), 32'(m_busy));
    checkOutput("frame_done", 32'(frame_done), 32'(m_done));
    checkOutput("fmt_err", 32'(fmt_err), 32'(m_err));
    if (m_busy) checkOutput("grant_id", 32'(grant_id), 32'(m_src));
    else if (m_fresh) checkOutput("grant_id_reset", 32'(grant_id), 32'd0);
    checkOutput("in0_ready", 32'(in0_if.tReady),
                32'((m_phase == 1 && m_src == 0) ? rdy : (dv[0] && !du[0])));
    checkOutput("in1_ready", 32'(in1_if.tReady),
                32'((m_phase == 1 && m_src == 1) ? rdy : (dv[1] && !du[1])));
    if (m_phase == 0) begin
      checkOutput("idle_user", 32'(out_if.tUser), 32'd0);
      checkOutput("idle_last", 32'(out_if.tLast), 32'd0);
    end
    if (ev) begin
      if (exp_q.size() == 0) begin
        checkOutput("exp_queue", 32'(exp_q.size()), 32'd1);
      end else begin
        eb = exp_q[0];
        checkOutput("out_data", 32'(out_if.tData), 32'(eb.data));
        checkOutput("out_user", 32'(out_if.tUser), 32'(eb.user));
        checkOutput("out_last", 32'(out_if.tLast), 32'(eb.last));
      end
    end
    if (m_new && m_busy) begin
      seen_grants.push_back(int'(grant_id));
      m_new = 1'b0;
    end
  endtask

  task automatic modelStep();
    bit e0, e1;
    int s;
    beat_t nb;
    m_done = 1'b0;
    if (reset) begin
      m_phase = 0; m_busy = 0; m_err = 0; m_last = 1; m_fresh = 1; m_new = 0;
      exp_q.delete();
      return;
    end
    case (m_phase)
      0: begin
        e0 = dv[0] && du[0];
        e1 = dv[1] && du[1];
        if (e0 || e1) begin
          s = (e0 && e1) ? (m_last ? 0 : 1) : (e1 ? 1 : 0);
          m_phase = 1; m_src = s; m_beat = 0; m_busy = 1; m_fresh = 0; m_new = 1;
          for (int k = 0; k < FRAME && k < qsize(s); k++) begin
            nb = qat(s, k);
            nb.user = (k == 0);
            nb.last = ((k % W) == W - 1);
            exp_q.push_back(nb);
          end
        end
      end
      1: if (s_hs_out) begin
        if ((dl[m_src] != ((m_beat % W) == W - 1)) || (du[m_src] && m_beat != 0)) m_err = 1;
        void'(exp_q.pop_front());
        m_beat++;
        if (m_beat == FRAME) begin
          m_last = (m_src == 1);
          if (EXP_FLUSH > 0) begin
            m_phase = 2; m_flush = 0;
            for (int k = 0; k < EXP_FLUSH; k++) begin
              nb.data = 8'h00; nb.user = 1'b0; nb.last = ((k % W) == W - 1);
              exp_q.push_back(nb);
            end
          end else begin
            m_phase = 0; m_busy = 0; m_done = 1;
          end
        end
      end
      2: if (s_hs_out) begin
        void'(exp_q.pop_front());
        m_flush++;
        if (m_flush == EXP_FLUSH) begin
          m_phase = 0; m_busy = 0; m_done = 1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus();
    beat_t b;
    if (s_hs_in[0]) void'(q0.pop_front());
    if (s_hs_in[1]) void'(q1.pop_front());
    reset = rst_req;
    for (int i = 0; i < 2; i++) begin
      if (rst_req || qsize(i) == 0) dv[i] = 1'b0;
      else if (!dv[i] || s_hs_in[i]) dv[i] = ($urandom_range(99) < p_valid);
      if (dv[i]) begin
        b = qat(i, 0);
        dd[i] = b.data; du[i] = b.user; dl[i] = b.last;
      end else begin
        dd[i] = 8'($urandom); du[i] = 1'b0; dl[i] = 1'b0;
      end
    end
    if (stall_beat >= 0 && m_phase == 1 && m_beat == stall_beat) begin
      stall_left = 5; stall_beat = -1;
    end
    if (stall_flush >= 0 && m_phase == 2 && m_flush == stall_flush) begin
      stall_left = 5; stall_flush = -1;
    end
    if (stall_left > 0) begin
      rdy = 1'b0; stall_left--;
    end else begin
      rdy = ($urandom_range(99) < p_ready);
    end
  endtask

  task automatic runCycle();
    @(negedge clk);
    checkCycle();
    @(posedge clk);
    #1;
    modelStep();
    applyStimulus();
  endtask

  task automatic pulseReset();
    rst_req = 1'b1;
    runCycle();
    rst_req = 1'b0;
    runCycle();
  endtask

  task automatic runUntilIdle(input int limit);
    int n = 0;
    bit drained = 1'b0;
    while (n < limit && !drained) begin
      runCycle();
      n++;
      drained = (m_phase == 0 && q0.size() == 0 && q1.size() == 0 && !m_done);
    end
    checkOutput("drain", 32'(drained), 32'd1);
    runCycle();
    runCycle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int exp_order [4] = '{0, 1, 0, 1};
    dd[0] = 8'h00; dd[1] = 8'h00;
    runCycle();
    runCycle();
    rst_req = 1'b0;
    runCycle();

    $display("[TB] single source frame");
    p_valid = 100; p_ready = 100;
    enqueueFrame(0, 8'h10, -1, 0);
    runUntilIdle(200);

    $display("[TB] simultaneous SOF round-robin");
    pulseReset();
    seen_grants.delete();
    enqueueFrame(0, 8'h20, -1, 0);
    enqueueFrame(1, 8'h40, -1, 0);
    enqueueFrame(0, 8'h60, -1, 0);
    enqueueFrame(1, 8'h80, -1, 0);
    runUntilIdle(400);
    checkOutput("grant_count", 32'(seen_grants.size()), 32'd4);
    for (int k = 0; k < 4 && k < seen_grants.size(); k++)
      checkOutput($sformatf("grant_order%0d", k), 32'(seen_grants[k]), 32'(exp_order[k]));

    $display("[TB] resync on source 1");
    enqueueGarbage(1, 3);
    enqueueFrame(1, 8'hA0, -1, 0);
    runUntilIdle(200);

    $display("[TB] back-pressure mid-line and mid-flush");
    stall_beat = 6;
    stall_flush = (EXP_FLUSH > 0) ? 4 : -1;
    enqueueFrame(0, 8'hC0, -1, 0);
    runUntilIdle(200);

    $display("[TB] marker error");
    enqueueFrame(0, 8'h30, 2, 1);
    runUntilIdle(200);
    checkOutput("fmt_err_sticky", 32'(fmt_err), 32'd1);

    $display("[TB] reset mid-frame");
    enqueueFrame(0, 8'h50, -1, 0);
    n = 0;
    while (!(m_phase == 1 && m_beat >= 6) && n < 200) begin
      runCycle();
      n++;
    end
    checkOutput("reach_beat6", 32'(m_phase == 1 && m_beat >= 6), 32'd1);
    pulseReset();
    enqueueFrame(1, 8'h70, -1, 0);
    runUntilIdle(400);

    $display("[TB] randomized traffic");
    pulseReset();
    p_valid = 70; p_ready = 75;
    for (int f = 0; f < 10; f++) begin
      int src;
      int eb;
      src = int'($urandom_range(1));
      enqueueGarbage(src, int'($urandom_range(2)));
      eb = ($urandom_range(7) == 0) ? int'($urandom_range(FRAME - 1, 1)) : -1;
      enqueueFrame(src, 8'($urandom), eb, int'($urandom_range(2, 1)));
    end
    runUntilIdle(5000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
